// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall sequencer for the five-stage pipeline: load-use bubbles,
// taken-branch flushes and multi-cycle memory waits with a timeout trap.
module pipeline_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        nreset,
   input  logic [4:0]  id_src_a,
   input  logic [4:0]  id_src_b,
   input  logic        id_src_a_used,
   input  logic        id_src_b_used,
   input  logic [4:0]  ex_dst,
   input  logic [1:0]  ex_wen,
   input  logic        ex_is_load,
   input  logic        branch_taken,
   input  logic        mem_req,
   input  logic        mem_ack,
   input  logic        perf_clear,
   output logic        stall_pc,
   output logic        stall_if_id,
   output logic        stall_id_ex,
   output logic        stall_ex_mem,
   output logic        stall_mem_wb,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        mem_timeout_err,
   output logic [1:0]  state,
   output logic [15:0] stall_cycles
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_ERROR    = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_W = 8'(MEM_TIMEOUT);

   state_t      state_r;
   state_t      state_nxt_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_nxt_s;
   logic [7:0]  cnt_inc_s;
   logic        err_r;
   logic        err_nxt_s;
   logic [15:0] stall_cycles_r;
   logic        memwait_s;
   logic        luse_s;
   logic        in_error_s;

   assign memwait_s  = mem_req & ~mem_ack;
   assign luse_s     = ex_is_load & (ex_wen != 2'b00) &
                       ((id_src_a_used & (id_src_a == ex_dst)) |
                        (id_src_b_used & (id_src_b == ex_dst)));
   assign cnt_inc_s  = wait_cnt_r + 8'd1;
   // The unused encoding is treated as a fault so the pipeline stays frozen.
   assign in_error_s = (state_r != ST_RUN) && (state_r != ST_MEM_WAIT);

   // State, wait counter and sticky error register.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         state_r    <= ST_RUN;
         wait_cnt_r <= 8'd0;
         err_r      <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         wait_cnt_r <= wait_cnt_nxt_s;
         err_r      <= err_nxt_s;
      end
   end

   // Next state: wait_cnt holds the number of memwait cycles already seen,
   // so the trap fires on the edge ending the MEM_TIMEOUT-th one.
   always_comb begin
      state_nxt_s    = state_r;
      wait_cnt_nxt_s = wait_cnt_r;
      err_nxt_s      = err_r;
      case (state_r)
         ST_RUN, ST_MEM_WAIT: begin
            if (memwait_s) begin
               if (cnt_inc_s == TIMEOUT_W) begin
                  state_nxt_s    = ST_ERROR;
                  wait_cnt_nxt_s = 8'd0;
                  err_nxt_s      = 1'b1;
               end else begin
                  state_nxt_s    = ST_MEM_WAIT;
                  wait_cnt_nxt_s = cnt_inc_s;
               end
            end else begin
               state_nxt_s    = ST_RUN;
               wait_cnt_nxt_s = 8'd0;
            end
         end
         ST_ERROR: begin
            state_nxt_s    = ST_ERROR;
            wait_cnt_nxt_s = 8'd0;
         end
         default: begin
            state_nxt_s    = ST_ERROR;
            wait_cnt_nxt_s = 8'd0;
            err_nxt_s      = 1'b1;
         end
      endcase
   end

   // Stall/flush priority: error, memory wait, branch, load-use.
   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      stall_mem_wb = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      if (!nreset) begin
         stall_pc = 1'b0;
      end else if (in_error_s || memwait_s) begin
         stall_pc     = 1'b1;
         stall_if_id  = 1'b1;
         stall_id_ex  = 1'b1;
         stall_ex_mem = 1'b1;
         stall_mem_wb = 1'b1;
      end else if (branch_taken) begin
         flush_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else if (luse_s) begin
         stall_pc    = 1'b1;
         stall_if_id = 1'b1;
         flush_id_ex = 1'b1;
      end else begin
         stall_pc = 1'b0;
      end
   end

   // Saturating count of PC-stall cycles; clear wins over increment.
   always_ff @(posedge clock) begin
      if (!nreset) begin
         stall_cycles_r <= 16'd0;
      end else if (perf_clear) begin
         stall_cycles_r <= 16'd0;
      end else if (stall_pc && (stall_cycles_r != 16'hFFFF)) begin
         stall_cycles_r <= stall_cycles_r + 16'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign state           = state_r;
   assign mem_timeout_err = err_r;
   assign stall_cycles    = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

   logic       clock = 1'b0;
   logic       nreset = 1'b0;
   logic [4:0] id_src_a = 5'd0, id_src_b = 5'd0, ex_dst = 5'd0;
   logic       id_src_a_used = 1'b0, id_src_b_used = 1'b0;
   logic [1:0] ex_wen = 2'd0;
   logic       ex_is_load = 1'b0, branch_taken = 1'b0;
   logic       mem_req = 1'b0, mem_ack = 1'b0, perf_clear = 1'b0;

   // control vectors: {stall_pc, if_id, id_ex, ex_mem, mem_wb, flush_if_id, flush_id_ex}
   wire [6:0]  ctl1, ctl2;
   wire        err1, err2;
   wire [1:0]  st1, st2;
   wire [15:0] sc1, sc2;

   int  n_checks = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(16)) u1 (
      .clock(clock), .nreset(nreset),
      .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
      .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
      .perf_clear(perf_clear),
      .stall_pc(ctl1[6]), .stall_if_id(ctl1[5]), .stall_id_ex(ctl1[4]),
      .stall_ex_mem(ctl1[3]), .stall_mem_wb(ctl1[2]),
      .flush_if_id(ctl1[1]), .flush_id_ex(ctl1[0]),
      .mem_timeout_err(err1), .state(st1), .stall_cycles(sc1)
   );

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(1)) u2 (
      .clock(clock), .nreset(nreset),
      .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
      .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
      .perf_clear(perf_clear),
      .stall_pc(ctl2[6]), .stall_if_id(ctl2[5]), .stall_id_ex(ctl2[4]),
      .stall_ex_mem(ctl2[3]), .stall_mem_wb(ctl2[2]),
      .flush_if_id(ctl2[1]), .flush_id_ex(ctl2[0]),
      .mem_timeout_err(err2), .state(st2), .stall_cycles(sc2)
   );

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   localparam int TO [2] = '{16, 1};
   int         m_cnt [2] = '{0, 0};   // consecutive memwait cycles so far
   bit         m_err [2] = '{1'b0, 1'b0};
   int         m_sc  [2] = '{0, 0};
   logic [6:0] exp_v [2];

   function automatic logic [6:0] exp_ctl(input bit err);
      bit memwait, luse;
      memwait = mem_req && !mem_ack;
      luse = ex_is_load && (ex_wen != 2'b00) &&
             ((id_src_a_used && id_src_a == ex_dst) || (id_src_b_used && id_src_b == ex_dst));
      if (!nreset)           return 7'b0000000;
      else if (err)          return 7'b1111100;
      else if (memwait)      return 7'b1111100;
      else if (branch_taken) return 7'b0000011;
      else if (luse)         return 7'b1100001;
      else                   return 7'b0000000;
   endfunction

   function automatic int exp_state(input int k);
      if (m_err[k]) return 2;
      return (m_cnt[k] > 0) ? 1 : 0;
   endfunction

   always_comb begin
      exp_v[0] = exp_ctl(m_err[0]);
      exp_v[1] = exp_ctl(m_err[1]);
   end

   always @(posedge clock) begin
      for (int k = 0; k < 2; k++) begin
         if (!nreset) begin
            m_cnt[k] <= 0;
            m_err[k] <= 1'b0;
            m_sc[k]  <= 0;
         end else begin
            if (!m_err[k]) begin
               if (mem_req && !mem_ack) begin
                  if (m_cnt[k] + 1 >= TO[k]) begin
                     m_err[k] <= 1'b1;
                     m_cnt[k] <= 0;
                  end else begin
                     m_cnt[k] <= m_cnt[k] + 1;
                  end
               end else begin
                  m_cnt[k] <= 0;
               end
            end
            if (perf_clear)                       m_sc[k] <= 0;
            else if (exp_v[k][6] && m_sc[k] < 65535) m_sc[k] <= m_sc[k] + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge clock) begin
      if (chk_en) begin
         check("ctl1",   32'(ctl1), 32'(exp_v[0]));
         check("state1", 32'(st1),  32'(exp_state(0)));
         check("err1",   32'(err1), 32'(m_err[0]));
         check("sc1",    32'(sc1),  32'(m_sc[0]));
         check("ctl2",   32'(ctl2), 32'(exp_v[1]));
         check("state2", 32'(st2),  32'(exp_state(1)));
         check("err2",   32'(err2), 32'(m_err[1]));
         check("sc2",    32'(sc2),  32'(m_sc[1]));
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic set_idle();
      id_src_a = 5'd0; id_src_b = 5'd0; id_src_a_used = 1'b0; id_src_b_used = 1'b0;
      ex_dst = 5'd0; ex_wen = 2'd0; ex_is_load = 1'b0; branch_taken = 1'b0;
      mem_req = 1'b0; mem_ack = 1'b0; perf_clear = 1'b0;
   endtask

   initial begin
      set_idle();
      nreset = 1'b0;
      tick();
      chk_en = 1'b1;
      tick();
      check("rst_ctl",   32'(ctl1), 32'h0);
      check("rst_state", 32'(st1),  32'h0);
      check("rst_err",   32'(err1), 32'h0);
      check("rst_sc",    32'(sc1),  32'h0);
      nreset = 1'b1;
      tick();

      // load-use bubble lasts one cycle
      ex_is_load = 1'b1; ex_wen = 2'b01; ex_dst = 5'd5; id_src_a = 5'd5; id_src_a_used = 1'b1;
      #1 check("luse_ctl", 32'(ctl1), 32'h61);
      tick();
      ex_is_load = 1'b0;
      #1 check("luse_next_ctl", 32'(ctl1), 32'h0);
      check("luse_sc", 32'(sc1), 32'd1);

      // branch kills the dependent instruction
      ex_is_load = 1'b1; branch_taken = 1'b1;
      #1 check("br_ctl", 32'(ctl1), 32'h03);
      tick();
      set_idle();
      check("br_sc", 32'(sc1), 32'd1);
      perf_clear = 1'b1;
      tick();
      perf_clear = 1'b0;
      check("clr_sc", 32'(sc1), 32'd0);

      // three-cycle memory wait, then ack
      mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex_is_load = 1'b1; ex_wen = 2'b10; ex_dst = 5'd9; id_src_b = 5'd9; id_src_b_used = 1'b1;
         #1 check("mw_ctl", 32'(ctl1), 32'h7C);
         tick();
         check("mw_state", 32'(st1), 32'd1);
         if (i == 0) check("t1_state", 32'(st2), 32'd2);
      end
      mem_ack = 1'b1;
      #1 check("ack_ctl", 32'(ctl1), 32'h61);
      tick();
      check("ack_state", 32'(st1), 32'd0);
      check("ack_sc",    32'(sc1), 32'd4);
      set_idle();

      // timeout after 16 memwait cycles
      mem_req = 1'b1;
      repeat (15) tick();
      check("to_pre_state", 32'(st1), 32'd1);
      tick();
      check("to_state", 32'(st1), 32'd2);
      check("to_err",   32'(err1), 32'd1);
      mem_ack = 1'b1;
      #1 check("err_ack_ctl", 32'(ctl1), 32'h7C);

      // ERROR stalls every cycle: counter saturates
      repeat (65540) tick();
      check("sat_sc", 32'(sc1), 32'hFFFF);
      perf_clear = 1'b1;
      tick();
      perf_clear = 1'b0;
      check("sat_clr_sc", 32'(sc1), 32'd0);
      tick();
      check("sat_inc_sc", 32'(sc1), 32'd1);
      nreset = 1'b0;
      #1 check("err_rst_ctl", 32'(ctl1), 32'h0);
      tick();
      nreset = 1'b1;
      check("err_rst_state", 32'(st1), 32'd0);
      check("err_rst_err",   32'(err1), 32'd0);
      set_idle();
      tick();

      // reset mid-wait restarts the full timeout
      mem_req = 1'b1;
      repeat (7) tick();
      check("mid_state", 32'(st1), 32'd1);
      nreset = 1'b0;
      #1 check("mid_rst_ctl", 32'(ctl1), 32'h0);
      tick();
      nreset = 1'b1;
      check("mid_rst_state", 32'(st1), 32'd0);
      repeat (15) tick();
      check("mid_pre_state", 32'(st1), 32'd1);
      tick();
      check("mid_to_state", 32'(st1), 32'd2);
      nreset = 1'b0;
      set_idle();
      tick();
      nreset = 1'b1;

      // randomized traffic, checked by the per-cycle compare process
      repeat (4000) begin
         id_src_a      = 5'($urandom_range(0, 3));
         id_src_b      = 5'($urandom_range(0, 3));
         ex_dst        = 5'($urandom_range(0, 3));
         id_src_a_used = 1'($urandom_range(0, 1));
         id_src_b_used = 1'($urandom_range(0, 1));
         ex_wen        = 2'($urandom_range(0, 3));
         ex_is_load    = 1'($urandom_range(0, 1));
         branch_taken  = ($urandom_range(0, 4) == 0);
         mem_req       = ($urandom_range(0, 2) != 0);
         mem_ack       = ($urandom_range(0, 2) == 0);
         perf_clear    = ($urandom_range(0, 49) == 0);
         nreset        = ($urandom_range(0, 299) != 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
